tns_rx_link_monitor: RTL and testbench

- Receive-side stage directly downstream of the 24-TSV TNS encoder; sits on the TSV bus in front of the TNS decoder.
- Registers each received TSV word and forwards it unchanged to the decoder.
- Checks every 3-TSV group against the encoder's transition rule, using the per-group bit-2 history.
- Maintains link lock status, error counters and a sticky error flag for debug and status readback.

---
 rtl/tns_rx_link_monitor.sv | 173 +++++++++++++++++
 tb/tb_tns_rx_link_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tns_rx_link_monitor.sv
// Receive-side TNS link monitor: forwards each TSV word with a fixed latency of 2,
// flags per-group transition-rule violations and tracks link lock and error statistics.
module tns_rx_link_monitor #(
  parameter int unsigned NGRP      = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LOSS_TH   = 4,
  parameter int unsigned RELOCK_TH = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [3*NGRP-1:0] tsv_in,
  input  logic              clear_cnt,
  output logic              out_valid,
  output logic [3*NGRP-1:0] out_tsv,
  output logic [NGRP-1:0]   out_grp_err,
  output logic              out_word_err,
  output logic              lock,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_word_cnt,
  output logic [7:0]        lost_cnt
);

  localparam int unsigned W    = 3 * NGRP;
  localparam int unsigned RUNW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_LOST   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              s1_valid_q;
  logic [W-1:0]      s1_tsv_q;
  logic [NGRP-1:0]   prev_b2_q, prev_b2_d;
  logic [RUNW-1:0]   consec_err_q, consec_err_d;
  logic [RUNW-1:0]   consec_clean_q, consec_clean_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_tsv_q, out_tsv_d;
  logic [NGRP-1:0]   out_grp_err_q, out_grp_err_d;
  logic              out_word_err_q, out_word_err_d;
  logic              lock_q, lock_d;
  logic              err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]  err_word_cnt_q, err_word_cnt_d;
  logic [7:0]        lost_cnt_q, lost_cnt_d;
  logic [NGRP-1:0]   grp_err_c;
  logic              word_err_c;

  // Stage-2 group check: a (b0,b1,b2)=(0,0,1) after b2=0, or (1,1,0) after b2=1, is illegal
  always_comb begin
    grp_err_c = '0;
    for (int unsigned j = 0; j < NGRP; j++) begin
      if ((s1_tsv_q[3*j +: 3] == 3'b100) && !prev_b2_q[j]) grp_err_c[j] = 1'b1;
      if ((s1_tsv_q[3*j +: 3] == 3'b011) &&  prev_b2_q[j]) grp_err_c[j] = 1'b1;
    end
    word_err_c = |grp_err_c;
  end

  // Next-state: forwarding, bit-2 history, lock FSM and statistics
  always_comb begin
    state_d        = state_q;
    prev_b2_d      = prev_b2_q;
    consec_err_d   = consec_err_q;
    consec_clean_d = consec_clean_q;
    out_valid_d    = s1_valid_q;
    out_tsv_d      = out_tsv_q;
    out_grp_err_d  = out_grp_err_q;
    lock_d         = lock_q;
    err_sticky_d   = err_sticky_q;
    err_word_cnt_d = err_word_cnt_q;
    lost_cnt_d     = lost_cnt_q;

    if (s1_valid_q) begin
      out_tsv_d     = s1_tsv_q;
      out_grp_err_d = (state_q == ST_IDLE) ? '0 : grp_err_c;
      for (int unsigned j = 0; j < NGRP; j++) prev_b2_d[j] = s1_tsv_q[3*j + 2];

      case (state_q)
        ST_IDLE: begin
          // First valid word is the sync word and is never checked
          state_d = ST_LOCKED;
          lock_d  = 1'b1;
        end
        ST_LOCKED: begin
          if (word_err_c) begin
            if (err_word_cnt_q != '1) err_word_cnt_d = err_word_cnt_q + CNT_W'(1);
            err_sticky_d = 1'b1;
            if ((consec_err_q + RUNW'(1)) == RUNW'(LOSS_TH)) begin
              state_d      = ST_LOST;
              lock_d       = 1'b0;
              consec_err_d = '0;
              if (lost_cnt_q != 8'hFF) lost_cnt_d = lost_cnt_q + 8'd1;
            end else begin
              consec_err_d = consec_err_q + RUNW'(1);
            end
          end else begin
            consec_err_d = '0;
          end
        end
        ST_LOST: begin
          if (word_err_c) begin
            consec_clean_d = '0;
          end else if ((consec_clean_q + RUNW'(1)) == RUNW'(RELOCK_TH)) begin
            state_d        = ST_LOCKED;
            lock_d         = 1'b1;
            consec_clean_d = '0;
          end else begin
            consec_clean_d = consec_clean_q + RUNW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          lock_d  = 1'b0;
        end
      endcase
    end

    // Clear wins over any same-edge increment or sticky set
    if (clear_cnt) begin
      err_word_cnt_d = '0;
      lost_cnt_d     = '0;
      err_sticky_d   = 1'b0;
    end

    out_word_err_d = |out_grp_err_d;
  end

  // State and pipeline registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      s1_valid_q     <= 1'b0;
      s1_tsv_q       <= '0;
      prev_b2_q      <= '0;
      consec_err_q   <= '0;
      consec_clean_q <= '0;
      out_valid_q    <= 1'b0;
      out_tsv_q      <= '0;
      out_grp_err_q  <= '0;
      out_word_err_q <= 1'b0;
      lock_q         <= 1'b0;
      err_sticky_q   <= 1'b0;
      err_word_cnt_q <= '0;
      lost_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      s1_valid_q     <= in_valid;
      if (in_valid) s1_tsv_q <= tsv_in;
      prev_b2_q      <= prev_b2_d;
      consec_err_q   <= consec_err_d;
      consec_clean_q <= consec_clean_d;
      out_valid_q    <= out_valid_d;
      out_tsv_q      <= out_tsv_d;
      out_grp_err_q  <= out_grp_err_d;
      out_word_err_q <= out_word_err_d;
      lock_q         <= lock_d;
      err_sticky_q   <= err_sticky_d;
      err_word_cnt_q <= err_word_cnt_d;
      lost_cnt_q     <= lost_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_tsv      = out_tsv_q;
  assign out_grp_err  = out_grp_err_q;
  assign out_word_err = out_word_err_q;
  assign lock         = lock_q;
  assign err_sticky   = err_sticky_q;
  assign err_word_cnt = err_word_cnt_q;
  assign lost_cnt     = lost_cnt_q;

endmodule

// File: tb/tb_tns_rx_link_monitor.sv
// Directed bench for tns_rx_link_monitor: vector table plus gap and mid-stream reset sequences.
module tb_tns_rx_link_monitor;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [23:0] tsv_in;
  logic        clear_cnt;
  logic        out_valid;
  logic [23:0] out_tsv;
  logic [7:0]  out_grp_err;
  logic        out_word_err;
  logic        lock;
  logic        err_sticky;
  logic [15:0] err_word_cnt;
  logic [7:0]  lost_cnt;

  int n_vec;
  int n_err;

  typedef struct {
    logic        v;
    logic [23:0] d;
    logic        clr;
    logic        ov;
    logic [23:0] tsv;
    logic [7:0]  grp;
    logic        lk;
    logic        sticky;
    logic [15:0] cnt;
    logic [7:0]  lost;
  } vec_t;

  vec_t tbl[$];

  tns_rx_link_monitor #(
    .NGRP(8), .CNT_W(16), .LOSS_TH(4), .RELOCK_TH(3)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .tsv_in      (tsv_in),
    .clear_cnt   (clear_cnt),
    .out_valid   (out_valid),
    .out_tsv     (out_tsv),
    .out_grp_err (out_grp_err),
    .out_word_err(out_word_err),
    .lock        (lock),
    .err_sticky  (err_sticky),
    .err_word_cnt(err_word_cnt),
    .lost_cnt    (lost_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic add(input logic v, input logic [23:0] d, input logic clr,
                     input logic ov, input logic [23:0] tsv, input logic [7:0] grp,
                     input logic lk, input logic sticky, input logic [15:0] cnt,
                     input logic [7:0] lost);
    vec_t r;
    r.v = v; r.d = d; r.clr = clr; r.ov = ov; r.tsv = tsv; r.grp = grp;
    r.lk = lk; r.sticky = sticky; r.cnt = cnt; r.lost = lost;
    tbl.push_back(r);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge
  task automatic step(input logic v, input logic [23:0] d, input logic clr);
    in_valid  = v;
    tsv_in    = d;
    clear_cnt = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ov"},     32'(out_valid),    32'd0);
    chk({tag, "_tsv"},    32'(out_tsv),      32'd0);
    chk({tag, "_grp"},    32'(out_grp_err),  32'd0);
    chk({tag, "_werr"},   32'(out_word_err), 32'd0);
    chk({tag, "_lock"},   32'(lock),         32'd0);
    chk({tag, "_sticky"}, 32'(err_sticky),   32'd0);
    chk({tag, "_cnt"},    32'(err_word_cnt), 32'd0);
    chk({tag, "_lost"},   32'(lost_cnt),     32'd0);
  endtask

  // Gap-test state: previous input slot and bit-2 history of legal words
  logic        pv;
  logic [23:0] pd;
  logic [7:0]  pb;

  task automatic gstep(input logic v, input logic [23:0] d, input int k);
    step(v, d, 1'b0);
    chk($sformatf("gap%0d_ov", k), 32'(out_valid), 32'(pv));
    if (pv) begin
      chk($sformatf("gap%0d_tsv", k), 32'(out_tsv),     32'(pd));
      chk($sformatf("gap%0d_grp", k), 32'(out_grp_err), 32'd0);
    end
    pv = v;
    if (v) pd = d;
  endtask

  initial begin
    logic [23:0] w;
    int          gap;
    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    tsv_in    = '0;
    clear_cnt = 1'b0;

    // Expected outputs after each row show the word of the previous row (latency 2)
    add(1, 24'h000000, 0,  0, 24'h000000, 8'h00, 0, 0, 16'd0, 8'd0);
    add(1, 24'h924924, 0,  1, 24'h000000, 8'h00, 1, 0, 16'd0, 8'd0);
    add(1, 24'h000000, 0,  1, 24'h924924, 8'hFF, 1, 1, 16'd1, 8'd0);
    add(1, 24'h000004, 0,  1, 24'h000000, 8'h00, 1, 1, 16'd1, 8'd0);
    add(1, 24'h000003, 0,  1, 24'h000004, 8'h01, 1, 1, 16'd2, 8'd0);
    add(0, 24'h000000, 0,  1, 24'h000003, 8'h01, 1, 1, 16'd3, 8'd0);
    add(1, 24'h000000, 0,  0, 24'h000003, 8'h01, 1, 1, 16'd3, 8'd0);
    add(0, 24'h000000, 0,  1, 24'h000000, 8'h00, 1, 1, 16'd3, 8'd0);
    add(1, 24'h924924, 0,  0, 24'h000000, 8'h00, 1, 1, 16'd3, 8'd0);
    add(1, 24'h6DB6DB, 0,  1, 24'h924924, 8'hFF, 1, 1, 16'd4, 8'd0);
    add(1, 24'h924924, 0,  1, 24'h6DB6DB, 8'hFF, 1, 1, 16'd5, 8'd0);
    add(1, 24'h6DB6DB, 0,  1, 24'h924924, 8'hFF, 1, 1, 16'd6, 8'd0);
    add(1, 24'h000000, 0,  1, 24'h6DB6DB, 8'hFF, 0, 1, 16'd7, 8'd1);
    add(1, 24'h924924, 0,  1, 24'h000000, 8'h00, 0, 1, 16'd7, 8'd1);
    add(1, 24'h000000, 0,  1, 24'h924924, 8'hFF, 0, 1, 16'd7, 8'd1);
    add(1, 24'h000000, 0,  1, 24'h000000, 8'h00, 0, 1, 16'd7, 8'd1);
    add(1, 24'h000000, 0,  1, 24'h000000, 8'h00, 0, 1, 16'd7, 8'd1);
    add(0, 24'h000000, 0,  1, 24'h000000, 8'h00, 1, 1, 16'd7, 8'd1);
    add(0, 24'h000000, 0,  0, 24'h000000, 8'h00, 1, 1, 16'd7, 8'd1);
    add(1, 24'h924924, 0,  0, 24'h000000, 8'h00, 1, 1, 16'd7, 8'd1);
    add(0, 24'h000000, 0,  1, 24'h924924, 8'hFF, 1, 1, 16'd8, 8'd1);
    add(0, 24'h000000, 1,  0, 24'h924924, 8'hFF, 1, 0, 16'd0, 8'd0);
    add(1, 24'h6DB6DB, 0,  0, 24'h924924, 8'hFF, 1, 0, 16'd0, 8'd0);
    add(0, 24'h000000, 1,  1, 24'h6DB6DB, 8'hFF, 1, 0, 16'd0, 8'd0);
    add(1, 24'h924924, 0,  0, 24'h6DB6DB, 8'hFF, 1, 0, 16'd0, 8'd0);
    add(1, 24'h6DB6DB, 0,  1, 24'h924924, 8'hFF, 1, 1, 16'd1, 8'd0);
    add(0, 24'h000000, 1,  1, 24'h6DB6DB, 8'hFF, 0, 0, 16'd0, 8'd0);
    add(0, 24'h000000, 0,  0, 24'h6DB6DB, 8'hFF, 0, 0, 16'd0, 8'd0);

    #1;
    chk_zero("reset");
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].clr);
      chk($sformatf("r%0d_ov", i),     32'(out_valid),    32'(tbl[i].ov));
      chk($sformatf("r%0d_tsv", i),    32'(out_tsv),      32'(tbl[i].tsv));
      chk($sformatf("r%0d_grp", i),    32'(out_grp_err),  32'(tbl[i].grp));
      chk($sformatf("r%0d_werr", i),   32'(out_word_err), 32'(|tbl[i].grp));
      chk($sformatf("r%0d_lock", i),   32'(lock),         32'(tbl[i].lk));
      chk($sformatf("r%0d_sticky", i), 32'(err_sticky),   32'(tbl[i].sticky));
      chk($sformatf("r%0d_cnt", i),    32'(err_word_cnt), 32'(tbl[i].cnt));
      chk($sformatf("r%0d_lost", i),   32'(lost_cnt),     32'(tbl[i].lost));
    end

    // Random 1-5 cycle gaps between legal words; last valid word so far was 24'h6DB6DB
    pv = 1'b0;
    pd = 24'h6DB6DB;
    pb = 8'h00;
    for (int k = 0; k < 20; k++) begin
      gap = int'($urandom_range(1, 5));
      for (int g = 0; g < gap; g++) gstep(1'b0, 24'h000000, k);
      w = 24'($urandom);
      for (int g = 0; g < 8; g++) begin
        if ((w[3*g +: 3] == 3'b100) && !pb[g]) w[3*g +: 3] = 3'b101;
        if ((w[3*g +: 3] == 3'b011) &&  pb[g]) w[3*g +: 3] = 3'b111;
        pb[g] = w[3*g + 2];
      end
      gstep(1'b1, w, k);
    end
    gstep(1'b0, 24'h000000, 99);
    chk("gap_lock", 32'(lock), 32'd1);

    // Asynchronous reset in the middle of a burst
    step(1'b1, 24'h6DB6DB, 1'b0);
    in_valid = 1'b1;
    tsv_in   = 24'h924924;
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1'b1, 24'h924924, 1'b0);
    chk("post_rst_ov0", 32'(out_valid), 32'd0);
    step(1'b1, 24'h000000, 1'b0);
    chk("sync_ov",   32'(out_valid),   32'd1);
    chk("sync_tsv",  32'(out_tsv),     32'h924924);
    chk("sync_grp",  32'(out_grp_err), 32'd0);
    chk("sync_lock", 32'(lock),        32'd1);
    step(1'b0, 24'h000000, 1'b0);
    chk("sync2_grp", 32'(out_grp_err), 32'd0);
    chk("sync2_cnt", 32'(err_word_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
